// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter for up to 4 masters with split-transaction resume.
// Define ARB_TIMEOUT_EN to revoke grants held longer than TIMEOUT cycles.
module bus_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 3,
  parameter int TIMEOUT     = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_MASTERS-1:0]    m_req,
  input  logic [1:0]                response,
  input  logic [NUM_SLAVES-1:0]     slave_split_valid,
  input  logic [2*NUM_SLAVES-1:0]   slave_split_master,
  output logic [NUM_MASTERS-1:0]    m_grant,
  output logic [1:0]                granted_master,
  output logic                      grant_valid,
  output logic [NUM_MASTERS-1:0]    split_pending
);

  typedef enum logic [1:0] {
    IDLE,
    OWNED,
    RESUME
  } state_t;

  localparam logic [1:0] RSP_BUSY = 2'b01;
  localparam logic [1:0] RSP_DONE = 2'b11;

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [NUM_MASTERS-1:0] sp_q, sp_d;
  logic [1:0]             gm_q, gm_d;
  logic [1:0]             ptr_q, ptr_d;
  logic                   gv_q, gv_d;

  logic                   owner_req;
  logic                   busy;
  logic                   done;
  logic                   split_hit;
  logic [1:0]             split_id;
  logic                   rr_hit;
  logic [1:0]             rr_id;
  logic [NUM_MASTERS-1:0] elig;

`ifdef ARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^8'(TIMEOUT);
`endif

  function automatic logic [NUM_MASTERS-1:0] onehot(
    input logic [1:0] id
  );
    for (int i = 0; i < NUM_MASTERS; i++)
      onehot[i] = (id == 2'(i));
  endfunction

  // grant_q is one-hot on the owner, so it doubles as an owner mask
  assign owner_req = |(m_req & grant_q);
  assign busy      = (response == RSP_BUSY);
  assign done      = (response == RSP_DONE);
  assign elig      = m_req & ~sp_q;

  always_comb begin
    split_hit = 1'b0;
    split_id  = 2'd0;
    for (int k = 0; k < NUM_SLAVES; k++)
      for (int i = 0; i < NUM_MASTERS; i++)
        if (!split_hit && slave_split_valid[k] && sp_q[i] &&
            slave_split_master[2*k +: 2] == 2'(i)) begin
          split_hit = 1'b1;
          split_id  = 2'(i);
        end
  end

  always_comb begin
    rr_hit = 1'b0;
    rr_id  = 2'd0;
    for (int j = 0; j < NUM_MASTERS; j++)
      for (int i = 0; i < NUM_MASTERS; i++)
        if (!rr_hit && elig[i] &&
            ((int'(ptr_q) + j) % NUM_MASTERS) == i) begin
          rr_hit = 1'b1;
          rr_id  = 2'(i);
        end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sp_d    = sp_q;
    gm_d    = gm_q;
    ptr_d   = ptr_q;
    gv_d    = gv_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        grant_d = '0;
        gv_d    = 1'b0;
        if (split_hit) begin
          state_d = RESUME;
          grant_d = onehot(split_id);
          gm_d    = split_id;
          gv_d    = 1'b1;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = 8'd0;
`endif
        end else if (rr_hit) begin
          state_d = OWNED;
          grant_d = onehot(rr_id);
          gm_d    = rr_id;
          gv_d    = 1'b1;
          ptr_d   = (rr_id == 2'(NUM_MASTERS-1)) ?
                    2'd0 : rr_id + 2'd1;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = 8'd0;
`endif
        end
      end
      OWNED: begin
        if (busy) begin
          sp_d    = sp_q | grant_q;
          state_d = IDLE;
          grant_d = '0;
          gv_d    = 1'b0;
        end else if (!owner_req) begin
          state_d = IDLE;
          grant_d = '0;
          gv_d    = 1'b0;
`ifdef ARB_TIMEOUT_EN
        end else if (cnt_q + 8'd1 == 8'(TIMEOUT)) begin
          state_d = IDLE;
          grant_d = '0;
          gv_d    = 1'b0;
        end else begin
          cnt_d   = cnt_q + 8'd1;
`endif
        end
      end
      RESUME: begin
        if (done) begin
          sp_d    = sp_q & ~grant_q;
          state_d = IDLE;
          grant_d = '0;
          gv_d    = 1'b0;
        end else if (busy) begin
          state_d = IDLE;
          grant_d = '0;
          gv_d    = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        gv_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      sp_q    <= '0;
      gm_q    <= 2'd0;
      ptr_q   <= 2'd0;
      gv_q    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sp_q    <= sp_d;
      gm_q    <= gm_d;
      ptr_q   <= ptr_d;
      gv_q    <= gv_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign m_grant        = grant_q;
  assign granted_master = gm_q;
  assign grant_valid    = gv_q;
  assign split_pending  = sp_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: reset, round-robin, split/resume, timeout.
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] m_req;
  logic [1:0] response;
  logic [2:0] ssv;
  logic [5:0] ssm;
  logic [1:0] m_grant;
  logic [1:0] granted_master;
  logic       grant_valid;
  logic [1:0] split_pending;

  int n_asrt = 0;
  int n_fail = 0;

  bus_arbiter #(
    .NUM_MASTERS(2),
    .NUM_SLAVES (3),
    .TIMEOUT    (5)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .m_req             (m_req),
    .response          (response),
    .slave_split_valid (ssv),
    .slave_split_master(ssm),
    .m_grant           (m_grant),
    .granted_master    (granted_master),
    .grant_valid       (grant_valid),
    .split_pending     (split_pending)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag,
                         input logic [1:0] g,
                         input logic [1:0] gm,
                         input logic       gv,
                         input logic [1:0] sp);
    chk({tag, ".grant"}, 8'(m_grant), 8'(g));
    chk({tag, ".gm"}, 8'(granted_master), 8'(gm));
    chk({tag, ".gv"}, 8'(grant_valid), 8'(gv));
    chk({tag, ".sp"}, 8'(split_pending), 8'(sp));
  endtask

  initial begin
    reset = 1'b1;
    m_req = 2'b00;
    response = 2'b00;
    ssv = 3'b000;
    ssm = 6'b000000;
    step();
    step();
    chk_all("reset", 2'b00, 2'd0, 1'b0, 2'b00);
    reset = 1'b0;

    m_req = 2'b01;
    step();
    chk_all("grant0", 2'b01, 2'd0, 1'b1, 2'b00);

    reset = 1'b1;
    #1;
    chk_all("async_rst", 2'b00, 2'd0, 1'b0, 2'b00);
    reset = 1'b0;
    step();
    chk_all("regrant0", 2'b01, 2'd0, 1'b1, 2'b00);

    m_req = 2'b00;
    step();
    chk_all("release0", 2'b00, 2'd0, 1'b0, 2'b00);

    // pointer is now 1, so master 1 is served first
    m_req = 2'b11;
    for (int g = 0; g < 4; g++) begin
      logic [1:0] e;
      e = (g % 2 == 0) ? 2'd1 : 2'd0;
      step();
      chk("rr.first_gm", 8'(granted_master), 8'(e));
      chk("rr.first_gv", 8'(grant_valid), 8'd1);
      for (int c = 0; c < 3; c++) step();
      chk("rr.held_gm", 8'(granted_master), 8'(e));
      m_req = (e == 2'd1) ? 2'b01 : 2'b10;
      step();
      chk("rr.turnaround", 8'(grant_valid), 8'd0);
      m_req = (g < 3) ? 2'b11 : 2'b00;
    end

    m_req = 2'b10;
    step();
    chk_all("own1", 2'b10, 2'd1, 1'b1, 2'b00);
    response = 2'b01;
    step();
    chk_all("busy1", 2'b00, 2'd1, 1'b0, 2'b10);
    response = 2'b00;
    m_req = 2'b11;
    step();
    chk_all("mask1", 2'b01, 2'd0, 1'b1, 2'b10);
    m_req = 2'b10;
    step();
    chk_all("drop0", 2'b00, 2'd0, 1'b0, 2'b10);
    step();
    chk_all("ignored1", 2'b00, 2'd0, 1'b0, 2'b10);

    ssv = 3'b001;
    ssm = 6'b000000;
    step();
    chk_all("bogus_split", 2'b00, 2'd0, 1'b0, 2'b10);

    ssv = 3'b100;
    ssm = 6'b010000;
    step();
    chk_all("resume1", 2'b10, 2'd1, 1'b1, 2'b10);
    ssv = 3'b000;
    step();
    chk_all("resume_hold", 2'b10, 2'd1, 1'b1, 2'b10);
    response = 2'b11;
    step();
    chk_all("done1", 2'b00, 2'd1, 1'b0, 2'b00);
    response = 2'b00;

    m_req = 2'b01;
    step();
    chk_all("own0", 2'b01, 2'd0, 1'b1, 2'b00);
    response = 2'b01;
    m_req = 2'b00;
    step();
    chk_all("busy_drop", 2'b00, 2'd0, 1'b0, 2'b01);
    response = 2'b00;
    ssv = 3'b001;
    ssm = 6'b000000;
    m_req = 2'b10;
    step();
    chk_all("split_first", 2'b01, 2'd0, 1'b1, 2'b01);
    ssv = 3'b000;
    response = 2'b11;
    step();
    chk_all("done0", 2'b00, 2'd0, 1'b0, 2'b00);
    response = 2'b00;
    step();
    chk_all("then1", 2'b10, 2'd1, 1'b1, 2'b00);
    m_req = 2'b00;
    step();
    chk_all("rel1", 2'b00, 2'd1, 1'b0, 2'b00);

    m_req = 2'b01;
    step();
    chk_all("to_own0", 2'b01, 2'd0, 1'b1, 2'b00);
    m_req = 2'b11;
    for (int c = 0; c < 4; c++) step();
    chk_all("to_held", 2'b01, 2'd0, 1'b1, 2'b00);
    step();
`ifdef ARB_TIMEOUT_EN
    chk_all("to_revoke", 2'b00, 2'd0, 1'b0, 2'b00);
    step();
    chk_all("to_next1", 2'b10, 2'd1, 1'b1, 2'b00);
`else
    chk_all("no_timeout", 2'b01, 2'd0, 1'b1, 2'b00);
    step();
    chk_all("no_timeout2", 2'b01, 2'd0, 1'b1, 2'b00);
`endif
    m_req = 2'b00;
    step();
    chk("final_gv", 8'(grant_valid), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
